// File: rtl/text_input_ctrl.sv
// Key-code front end for the text editor: tracks the cursor on the character grid and
// turns accepted keys into single-cycle cell writes or clear requests, stalling for the wipe.
module text_input_ctrl #(
    parameter int          COLS         = 20,
    parameter int          ROWS         = 15,
    parameter int          CLEAR_CYCLES = 512,
    parameter logic [7:0]  BLANK        = 8'h20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [7:0] key_code,
    output logic       key_ready,
    output logic [8:0] write_addr,
    output logic [7:0] write_in_data,
    output logic       write_ready,
    output logic       clear_data,
    output logic [3:0] cursor_row,
    output logic [4:0] cursor_col
);
    localparam int         CW       = (CLEAR_CYCLES > 2) ? $clog2(CLEAR_CYCLES) : 1;
    localparam logic [4:0] LAST_COL = 5'(COLS - 1);
    localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);

    typedef enum logic [1:0] {IDLE, WRITE, CLEAR_WAIT} state_t;

    state_t         r_state, w_state_nxt;
    logic [CW-1:0]  r_cnt, w_cnt_nxt;
    logic [3:0]     r_row, w_row_nxt;
    logic [4:0]     r_col, w_col_nxt;
    logic [8:0]     r_addr, w_addr_nxt;
    logic [7:0]     r_data, w_data_nxt;
    logic           r_wr, w_wr_nxt;
    logic           r_clr, w_clr_nxt;

    logic w_accept, w_printable, w_bs, w_clear;

    assign w_accept    = key_valid & key_ready;
    assign w_printable = (key_code >= 8'h20) && (key_code <= 8'h7E);
    assign w_bs        = (key_code == 8'h08);
    assign w_clear     = (key_code == 8'h1B);

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_printable || w_bs) w_state_nxt = WRITE;
                    else if (w_clear)        w_state_nxt = CLEAR_WAIT;
                end
            end
            WRITE:      w_state_nxt = IDLE;
            CLEAR_WAIT: if (r_cnt == '0) w_state_nxt = IDLE;
            default:    w_state_nxt = IDLE;
        endcase
    end

    // Datapath next values; strobes default low so they last exactly one cycle.
    always_comb begin
        w_row_nxt  = r_row;
        w_col_nxt  = r_col;
        w_addr_nxt = r_addr;
        w_data_nxt = r_data;
        w_cnt_nxt  = r_cnt;
        w_wr_nxt   = 1'b0;
        w_clr_nxt  = 1'b0;
        if (r_state == CLEAR_WAIT && r_cnt != '0)
            w_cnt_nxt = r_cnt - 1'b1;
        if (w_accept) begin
            if (w_printable) begin
                w_wr_nxt   = 1'b1;
                w_addr_nxt = {r_row, r_col};
                w_data_nxt = key_code;
                if (r_col != LAST_COL) begin
                    w_col_nxt = r_col + 1'b1;
                end else if (r_row != LAST_ROW) begin
                    w_col_nxt = '0;
                    w_row_nxt = r_row + 1'b1;
                end
            end else if (w_bs) begin
                w_wr_nxt   = 1'b1;
                w_data_nxt = BLANK;
                w_addr_nxt = {r_row, r_col};
                if (r_col != '0) begin
                    w_col_nxt  = r_col - 1'b1;
                    w_addr_nxt = {r_row, r_col - 5'd1};
                end else if (r_row != '0) begin
                    w_row_nxt  = r_row - 1'b1;
                    w_col_nxt  = LAST_COL;
                    w_addr_nxt = {r_row - 4'd1, LAST_COL};
                end
            end else begin
                case (key_code)
                    8'h0D: begin
                        w_col_nxt = '0;
                        if (r_row != LAST_ROW) w_row_nxt = r_row + 1'b1;
                    end
                    8'h11: if (r_col != '0)       w_col_nxt = r_col - 1'b1;
                    8'h12: if (r_col != LAST_COL) w_col_nxt = r_col + 1'b1;
                    8'h13: if (r_row != '0)       w_row_nxt = r_row - 1'b1;
                    8'h14: if (r_row != LAST_ROW) w_row_nxt = r_row + 1'b1;
                    8'h1B: begin
                        w_clr_nxt = 1'b1;
                        w_row_nxt = '0;
                        w_col_nxt = '0;
                        w_cnt_nxt = CW'(CLEAR_CYCLES - 1);
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_row  <= '0;
            r_col  <= '0;
            r_addr <= '0;
            r_data <= '0;
            r_cnt  <= '0;
            r_wr   <= 1'b0;
            r_clr  <= 1'b0;
        end else begin
            r_row  <= w_row_nxt;
            r_col  <= w_col_nxt;
            r_addr <= w_addr_nxt;
            r_data <= w_data_nxt;
            r_cnt  <= w_cnt_nxt;
            r_wr   <= w_wr_nxt;
            r_clr  <= w_clr_nxt;
        end
    end

    assign key_ready     = (r_state == IDLE) & ~rst;
    assign write_addr    = r_addr;
    assign write_in_data = r_data;
    assign write_ready   = r_wr;
    assign clear_data    = r_clr;
    assign cursor_row    = r_row;
    assign cursor_col    = r_col;
endmodule

// File: tb/tb_text_input_ctrl.sv
// Scoreboard bench for text_input_ctrl: a cursor model queues expected strobes per key,
// a negedge monitor pops and compares them, and per-feature tasks check timing and cursor.
module tb_text_input_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_ready;
    logic [8:0] write_addr;
    logic [7:0] write_in_data;
    logic       write_ready;
    logic       clear_data;
    logic [3:0] cursor_row;
    logic [4:0] cursor_col;

    text_input_ctrl dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .key_ready(key_ready), .write_addr(write_addr), .write_in_data(write_in_data),
        .write_ready(write_ready), .clear_data(clear_data),
        .cursor_row(cursor_row), .cursor_col(cursor_col)
    );

    always #5 clk = ~clk;

    typedef struct { logic is_clr; logic [8:0] addr; logic [7:0] data; } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int m_row = 0;
    int m_col = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0) begin
            if (write_ready === 1'b1 && clear_data === 1'b1) begin
                checks++; errors++;
                $display("FAIL strobe_overlap: write_ready and clear_data both high at cycle %0d", cyc);
            end
            if (write_ready === 1'b1) begin
                checks++;
                if (sb.size() == 0 || sb[0].is_clr) begin
                    errors++;
                    $display("FAIL unexpected_write: addr=%h data=%h, no write expected", write_addr, write_in_data);
                end else begin
                    e = sb.pop_front();
                    if (write_addr !== e.addr || write_in_data !== e.data) begin
                        errors++;
                        $display("FAIL sb_write: got addr=%h data=%h, expected addr=%h data=%h",
                                 write_addr, write_in_data, e.addr, e.data);
                    end
                end
            end
            if (clear_data === 1'b1) begin
                checks++;
                if (sb.size() == 0 || !sb[0].is_clr) begin
                    errors++;
                    $display("FAIL unexpected_clear: clear_data high, no clear expected");
                end else begin
                    e = sb.pop_front();
                end
            end
        end
    end

    // Drive one key, waiting (bounded) for key_ready; update the reference model on accept.
    task automatic send(input logic [7:0] k);
        int t = 0;
        exp_t e;
        @(negedge clk);
        while (key_ready !== 1'b1 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) begin
            checks++; errors++;
            $display("FAIL send_timeout: key_ready=%b, expected 1 within 2000 cycles", key_ready);
            return;
        end
        key_valid = 1'b1;
        key_code  = k;
        if (k >= 8'h20 && k <= 8'h7E) begin
            e.is_clr = 1'b0; e.addr = 9'(m_row * 32 + m_col); e.data = k;
            sb.push_back(e);
            if (m_col < 19) m_col++;
            else if (m_row < 14) begin m_col = 0; m_row++; end
        end else if (k == 8'h08) begin
            if (m_col > 0) m_col--;
            else if (m_row > 0) begin m_row--; m_col = 19; end
            e.is_clr = 1'b0; e.addr = 9'(m_row * 32 + m_col); e.data = 8'h20;
            sb.push_back(e);
        end else if (k == 8'h0D) begin
            m_col = 0; if (m_row < 14) m_row++;
        end else if (k == 8'h11) begin if (m_col > 0) m_col--;
        end else if (k == 8'h12) begin if (m_col < 19) m_col++;
        end else if (k == 8'h13) begin if (m_row > 0) m_row--;
        end else if (k == 8'h14) begin if (m_row < 14) m_row++;
        end else if (k == 8'h1B) begin
            e.is_clr = 1'b1; e.addr = '0; e.data = '0;
            sb.push_back(e);
            m_row = 0; m_col = 0;
        end
        @(posedge clk);
        #1;
        acc_cyc   = cyc;
        key_valid = 1'b0;
    endtask

    task automatic press(input logic [7:0] k, input int n);
        for (int i = 0; i < n; i++) send(k);
    endtask

    task automatic test_reset;
        rst = 1'b1; key_valid = 1'b0; key_code = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if (key_ready !== 1'b0 || write_ready !== 1'b0 || clear_data !== 1'b0 ||
            write_addr !== 9'h000 || write_in_data !== 8'h00 ||
            cursor_row !== 4'd0 || cursor_col !== 5'd0) begin
            errors++;
            $display("FAIL reset_values: rdy=%b wr=%b clr=%b addr=%h data=%h cur=(%0d,%0d), expected all 0",
                     key_ready, write_ready, clear_data, write_addr, write_in_data, cursor_row, cursor_col);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (key_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: key_ready=%b, expected 1", key_ready);
        end
    endtask

    task automatic test_printable;
        send(8'h41);
        @(negedge clk);
        checks++;
        if (write_ready !== 1'b1 || write_addr !== 9'h000 || write_in_data !== 8'h41 ||
            cursor_row !== 4'd0 || cursor_col !== 5'd1) begin
            errors++;
            $display("FAIL print_A: wr=%b addr=%h data=%h cur=(%0d,%0d), expected 1 000 41 (0,1)",
                     write_ready, write_addr, write_in_data, cursor_row, cursor_col);
        end
        @(negedge clk);
        checks++;
        if (write_ready !== 1'b0) begin
            errors++; $display("FAIL print_pulse: write_ready=%b in second cycle, expected 0", write_ready);
        end
    endtask

    task automatic test_wrap;
        press(8'h12, 18);
        send(8'h42);
        @(negedge clk);
        checks++;
        if (write_addr !== {4'd0, 5'd19} || cursor_row !== 4'd1 || cursor_col !== 5'd0) begin
            errors++;
            $display("FAIL wrap_B: addr=%h cur=(%0d,%0d), expected 013 (1,0)", write_addr, cursor_row, cursor_col);
        end
        press(8'h14, 13);
        press(8'h12, 19);
        send(8'h43);
        @(negedge clk);
        checks++;
        if (write_addr !== 9'h1D3 || write_in_data !== 8'h43 || cursor_row !== 4'd14 || cursor_col !== 5'd19) begin
            errors++;
            $display("FAIL last_cell_C: addr=%h data=%h cur=(%0d,%0d), expected 1d3 43 (14,19)",
                     write_addr, write_in_data, cursor_row, cursor_col);
        end
    endtask

    task automatic test_backspace;
        press(8'h13, 12);
        press(8'h11, 19);
        send(8'h08);
        @(negedge clk);
        checks++;
        if (write_ready !== 1'b1 || write_addr !== 9'h033 || write_in_data !== 8'h20 ||
            cursor_row !== 4'd1 || cursor_col !== 5'd19) begin
            errors++;
            $display("FAIL bs_rowwrap: wr=%b addr=%h data=%h cur=(%0d,%0d), expected 1 033 20 (1,19)",
                     write_ready, write_addr, write_in_data, cursor_row, cursor_col);
        end
        send(8'h13);
        press(8'h11, 19);
        send(8'h08);
        @(negedge clk);
        checks++;
        if (write_ready !== 1'b1 || write_addr !== 9'h000 || write_in_data !== 8'h20 ||
            cursor_row !== 4'd0 || cursor_col !== 5'd0) begin
            errors++;
            $display("FAIL bs_origin: wr=%b addr=%h data=%h cur=(%0d,%0d), expected 1 000 20 (0,0)",
                     write_ready, write_addr, write_in_data, cursor_row, cursor_col);
        end
    endtask

    task automatic test_arrows;
        send(8'h11);
        send(8'h13);
        @(negedge clk);
        checks++;
        if (cursor_row !== 4'd0 || cursor_col !== 5'd0 || write_ready !== 1'b0) begin
            errors++;
            $display("FAIL arrow_edge: cur=(%0d,%0d) wr=%b, expected (0,0) 0", cursor_row, cursor_col, write_ready);
        end
        press(8'h14, 20);
        @(negedge clk);
        checks++;
        if (cursor_row !== 4'd14) begin
            errors++; $display("FAIL down_sat: row=%0d, expected 14", cursor_row);
        end
        press(8'h13, 11);
        press(8'h12, 7);
        send(8'h0D);
        @(negedge clk);
        checks++;
        if (cursor_row !== 4'd4 || cursor_col !== 5'd0) begin
            errors++; $display("FAIL enter: cur=(%0d,%0d), expected (4,0)", cursor_row, cursor_col);
        end
    endtask

    task automatic test_ignored;
        send(8'h00);
        send(8'h7F);
        send(8'hFF);
        @(negedge clk);
        checks++;
        if (cursor_row !== 4'd4 || cursor_col !== 5'd0 || write_ready !== 1'b0 || clear_data !== 1'b0) begin
            errors++;
            $display("FAIL ignored: cur=(%0d,%0d) wr=%b clr=%b, expected (4,0) 0 0",
                     cursor_row, cursor_col, write_ready, clear_data);
        end
    endtask

    task automatic test_back_to_back;
        int first;
        send(8'h78);
        first = acc_cyc;
        send(8'h79);
        checks++;
        if (acc_cyc - first != 2) begin
            errors++; $display("FAIL b2b_spacing: accept gap=%0d cycles, expected 2", acc_cyc - first);
        end
        @(negedge clk);
        checks++;
        if (write_addr !== 9'(4 * 32 + 1) || write_in_data !== 8'h79 || cursor_col !== 5'd2) begin
            errors++;
            $display("FAIL b2b_second: addr=%h data=%h col=%0d, expected 081 79 2", write_addr, write_in_data, cursor_col);
        end
    endtask

    task automatic test_clear;
        int c0;
        int bad = 0;
        send(8'h1B);
        c0 = acc_cyc;
        @(negedge clk);
        checks++;
        if (clear_data !== 1'b1 || key_ready !== 1'b0 || cursor_row !== 4'd0 || cursor_col !== 5'd0) begin
            errors++;
            $display("FAIL clear_pulse: clr=%b rdy=%b cur=(%0d,%0d), expected 1 0 (0,0)",
                     clear_data, key_ready, cursor_row, cursor_col);
        end
        for (int i = 2; i <= 512; i++) begin
            @(negedge clk);
            if (key_ready !== 1'b0 && bad == 0) bad = i;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL clear_stall: key_ready=1 at N+%0d, expected 0 through N+512", bad);
        end
        send(8'h5A);
        checks++;
        if (acc_cyc - c0 != 513) begin
            errors++; $display("FAIL clear_reaccept: next accept after %0d cycles, expected 513", acc_cyc - c0);
        end
        @(negedge clk);
        checks++;
        if (write_addr !== 9'h000 || write_in_data !== 8'h5A) begin
            errors++; $display("FAIL clear_first_write: addr=%h data=%h, expected 000 5a", write_addr, write_in_data);
        end
    endtask

    task automatic test_rst_mid_clear;
        send(8'h51);
        send(8'h1B);
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        m_row = 0; m_col = 0;
        checks++;
        if (key_ready !== 1'b0 || write_ready !== 1'b0 || clear_data !== 1'b0 ||
            write_addr !== 9'h000 || write_in_data !== 8'h00 ||
            cursor_row !== 4'd0 || cursor_col !== 5'd0) begin
            errors++;
            $display("FAIL rst_mid_clear: rdy=%b wr=%b clr=%b addr=%h data=%h cur=(%0d,%0d), expected all 0",
                     key_ready, write_ready, clear_data, write_addr, write_in_data, cursor_row, cursor_col);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (key_ready !== 1'b1) begin
            errors++; $display("FAIL rst_release_ready: key_ready=%b, expected 1", key_ready);
        end
        send(8'h52);
        @(negedge clk);
        checks++;
        if (write_addr !== 9'h000 || write_in_data !== 8'h52) begin
            errors++; $display("FAIL post_rst_write: addr=%h data=%h, expected 000 52", write_addr, write_in_data);
        end
    endtask

    initial begin
        rst = 1'b1; key_valid = 1'b0; key_code = 8'h00;
        test_reset();
        test_printable();
        test_wrap();
        test_backspace();
        test_arrows();
        test_ignored();
        test_back_to_back();
        test_clear();
        test_rst_mid_clear();
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL sb_drain: %0d expected strobes never seen, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
